// File: rtl/darc_axil_reg_slave.sv
// darc_axil_reg_slave: AXI4-Lite register bank for the DARC RLE accelerator.
// Single-beat reads and writes with byte strobes. Each register is driven
// out to the datapath on reg_out.
// Build option: define DARC_AXIL_SLVERR_EN to make out-of-range accesses
// return SLVERR. Without it, out-of-range indices alias modulo NUM_REGS.
module darc_axil_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_out
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int AW     = C_S_AXI_ADDR_WIDTH;
  localparam int STRB_W = DW / 8;
  localparam int WIDX_W = AW - 2;
  localparam int SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Write channel state
  logic              aw_held_reg;
  logic [AW-1:0]     aw_addr_reg;
  logic              w_held_reg;
  logic [DW-1:0]     w_data_reg;
  logic [STRB_W-1:0] w_strb_reg;
  logic              awready_reg;
  logic              wready_reg;
  logic              bvalid_reg;
  logic [1:0]        bresp_reg;

  // Read channel state
  logic              arready_reg;
  logic              rvalid_reg;
  logic [DW-1:0]     rdata_reg;
  logic [1:0]        rresp_reg;

  // Register bank
  logic [DW-1:0]     regs [NUM_REGS];

  // Write-side combinational decode
  logic              aw_hs;
  logic              w_hs;
  logic              have_aw;
  logic              have_w;
  logic              commit;
  logic              aw_held_next;
  logic              w_held_next;
  logic              bvalid_next;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [WIDX_W-1:0] wr_idx;
  logic [SEL_W-1:0]  wr_sel;
  logic              wr_ok;
  logic [1:0]        wr_resp;

  // Read-side combinational decode
  logic              ar_hs;
  logic              rvalid_next;
  logic [WIDX_W-1:0] rd_idx;
  logic [SEL_W-1:0]  rd_sel;
  logic              rd_ok;
  logic [1:0]        rd_resp;

  assign aw_hs   = S_AXI_AWVALID & awready_reg;
  assign w_hs    = S_AXI_WVALID & wready_reg;
  assign have_aw = aw_hs | aw_held_reg;
  assign have_w  = w_hs | w_held_reg;
  // Address and data may come from this edge's handshake or a held copy
  assign commit  = have_aw & have_w;

  assign aw_held_next = have_aw & ~commit;
  assign w_held_next  = have_w & ~commit;
  assign bvalid_next  = commit | (bvalid_reg & ~S_AXI_BREADY);

  assign wr_addr = aw_hs ? S_AXI_AWADDR : aw_addr_reg;
  assign wr_data = w_hs ? S_AXI_WDATA : w_data_reg;
  assign wr_strb = w_hs ? S_AXI_WSTRB : w_strb_reg;
  assign wr_idx  = wr_addr[AW-1:2];
  assign wr_sel  = wr_idx[SEL_W-1:0];

  assign ar_hs       = S_AXI_ARVALID & arready_reg;
  assign rvalid_next = ar_hs | (rvalid_reg & ~S_AXI_RREADY);
  assign rd_idx      = S_AXI_ARADDR[AW-1:2];
  assign rd_sel      = rd_idx[SEL_W-1:0];

`ifdef DARC_AXIL_SLVERR_EN
  assign wr_ok   = (32'(wr_idx) < 32'(NUM_REGS));
  assign rd_ok   = (32'(rd_idx) < 32'(NUM_REGS));
  assign wr_resp = wr_ok ? 2'b00 : 2'b10;
  assign rd_resp = rd_ok ? 2'b00 : 2'b10;
`else
  // Upper index bits are dropped so out-of-range accesses alias
  assign wr_ok   = 1'b1;
  assign rd_ok   = 1'b1;
  assign wr_resp = 2'b00;
  assign rd_resp = 2'b00;
`endif

  // Protection bits, byte-offset bits and aliased index bits carry no meaning
  logic unused_bits;
  assign unused_bits = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                         wr_addr[1:0], S_AXI_ARADDR[1:0], wr_idx, rd_idx};

  // Write handshake flags, held copies, readies and write response
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      aw_held_reg <= 1'b0;
      aw_addr_reg <= '0;
      w_held_reg  <= 1'b0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= 2'b00;
    end else begin
      aw_held_reg <= aw_held_next;
      w_held_reg  <= w_held_next;
      if (aw_hs) aw_addr_reg <= S_AXI_AWADDR;
      if (w_hs) begin
        w_data_reg <= S_AXI_WDATA;
        w_strb_reg <= S_AXI_WSTRB;
      end
      // Only one write outstanding: both readies stay low until B completes
      awready_reg <= ~aw_held_next & ~bvalid_next;
      wready_reg  <= ~w_held_next & ~bvalid_next;
      bvalid_reg  <= bvalid_next;
      if (commit) bresp_reg <= wr_resp;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic wr_hit;
      assign wr_hit = commit & wr_ok & (wr_sel == SEL_W'(gi));

      // Byte-lane update of one register on a committed write
      always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
          regs[gi] <= '0;
        end else if (wr_hit) begin
          for (int i = 0; i < STRB_W; i++) begin
            if (wr_strb[i]) regs[gi][8*i +: 8] <= wr_data[8*i +: 8];
          end
        end
      end

      assign reg_out[DW*gi +: DW] = regs[gi];
    end
  endgenerate

  // Read channel: capture the pre-write register value on the AR handshake
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      rresp_reg   <= 2'b00;
    end else begin
      arready_reg <= ~rvalid_next;
      rvalid_reg  <= rvalid_next;
      if (ar_hs) begin
        rdata_reg <= rd_ok ? regs[rd_sel] : '0;
        rresp_reg <= rd_resp;
      end
    end
  end

  assign S_AXI_AWREADY = awready_reg;
  assign S_AXI_WREADY  = wready_reg;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_BRESP   = bresp_reg;
  assign S_AXI_ARREADY = arready_reg;
  assign S_AXI_RVALID  = rvalid_reg;
  assign S_AXI_RDATA   = rdata_reg;
  assign S_AXI_RRESP   = rresp_reg;

endmodule

// File: tb/tb_darc_axil_reg_slave.sv
// Testbench for darc_axil_reg_slave: directed cases plus randomized traffic
// checked against a register-array model. Honours DARC_AXIL_SLVERR_EN.
module tb_darc_axil_reg_slave;

  localparam int NR = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   awaddr = '0;
  logic [2:0]   awprot = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [4:0]   araddr = '0;
  logic [2:0]   arprot = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [127:0] reg_out;

  darc_axil_reg_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .NUM_REGS(NR)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr),
    .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .reg_out(reg_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Behavioural model: plain array of register words
  logic [31:0] model [NR];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: no handshake within cycle budget", name);
  endtask

  function automatic void model_decode(input logic [4:0] a, output int idx, output bit ok);
    idx = int'(a[4:2]);
`ifdef DARC_AXIL_SLVERR_EN
    ok = (idx < NR);
`else
    ok = 1'b1;
    idx = idx % NR;
`endif
  endfunction

  function automatic void model_write(input logic [4:0] a, input logic [31:0] d,
                                      input logic [3:0] s, output logic [1:0] resp);
    int idx;
    bit ok;
    model_decode(a, idx, ok);
    resp = ok ? 2'b00 : 2'b10;
    if (ok) begin
      for (int i = 0; i < 4; i++)
        if (s[i]) model[idx][8*i +: 8] = d[8*i +: 8];
    end
  endfunction

  function automatic void model_read(input logic [4:0] a, output logic [31:0] d,
                                     output logic [1:0] resp);
    int idx;
    bit ok;
    model_decode(a, idx, ok);
    d = ok ? model[idx] : 32'h0;
    resp = ok ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [127:0] model_vec();
    logic [127:0] v;
    for (int k = 0; k < NR; k++) v[32*k +: 32] = model[k];
    return v;
  endfunction

  initial begin
    for (int k = 0; k < NR; k++) model[k] = 32'h0;
  end

  // Per-cycle compare process: register outputs, ready exclusion and hold rules
  logic       p_bvalid = 1'b0, p_bready = 1'b0, p_rvalid = 1'b0, p_rready = 1'b0;
  logic [1:0] p_bresp = '0, p_rresp = '0;
  logic [31:0] p_rdata = '0;

  always @(negedge clk) begin
    if (rst) begin
      p_bvalid = 1'b0;
      p_rvalid = 1'b0;
      p_bready = 1'b0;
      p_rready = 1'b0;
    end else begin
      check("reg_out_vs_model", reg_out, model_vec());
      if (bvalid) check("aw_w_ready_low_during_b", {awready, wready}, 2'b00);
      if (rvalid) check("arready_low_during_r", arready, 1'b0);
      if (p_bvalid && !p_bready) check("b_hold_stable", {bvalid, bresp}, {1'b1, p_bresp});
      if (p_rvalid && !p_rready)
        check("r_hold_stable", {rvalid, rresp, rdata}, {1'b1, p_rresp, p_rdata});
      p_bvalid = bvalid;
      p_bready = bready;
      p_bresp  = bresp;
      p_rvalid = rvalid;
      p_rready = rready;
      p_rresp  = rresp;
      p_rdata  = rdata;
    end
  end

  // Write transaction; called #1 after a rising edge
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output int aw_cyc, output int b_cyc, output logic [1:0] bresp_got);
    bit aw_done = 1'b0;
    bit w_done = 1'b0;
    bit aw_hs;
    bit w_hs;
    int c = 0;
    logic [1:0] exp_resp;
    aw_cyc = -1;
    b_cyc = -1;
    bresp_got = 2'b00;
    while (!(aw_done && w_done)) begin
      if (!aw_done && c >= aw_dly) begin
        awvalid = 1'b1;
        awaddr = a;
      end
      if (!w_done && c >= w_dly) begin
        wvalid = 1'b1;
        wdata = d;
        wstrb = s;
      end
      @(negedge clk);
      if (w_done && !aw_done) check("wready_low_while_w_held", wready, 1'b0);
      if (aw_done && !w_done) check("awready_low_while_aw_held", awready, 1'b0);
      aw_hs = awvalid && awready;
      w_hs = wvalid && wready;
      if (aw_hs) aw_cyc = cyc_cnt;
      @(posedge clk);
      #1;
      if (aw_hs) begin
        aw_done = 1'b1;
        awvalid = 1'b0;
      end
      if (w_hs) begin
        w_done = 1'b1;
        wvalid = 1'b0;
      end
      c++;
      if (c > 60) begin
        timeout_fail("write_handshake");
        awvalid = 1'b0;
        wvalid = 1'b0;
        return;
      end
    end
    // Commit happened on the edge just passed
    model_write(a, d, s, exp_resp);
    check("bvalid_one_cycle_after_commit", bvalid, 1'b1);
    repeat (b_dly) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    bready = 1'b1;
    @(negedge clk);
    check("bvalid_at_b_handshake", bvalid, 1'b1);
    check("bresp", bresp, exp_resp);
    bresp_got = bresp;
    b_cyc = cyc_cnt;
    @(posedge clk);
    #1;
    bready = 1'b0;
    $display("[TB] WR addr=%h data=%h strb=%h bresp=%0d", a, d, s, bresp_got);
  endtask

  // Read transaction; called #1 after a rising edge
  task automatic axi_read(input logic [4:0] a, input int r_dly,
                          output logic [31:0] got, output logic [1:0] gresp);
    logic [31:0] exp_d = '0;
    logic [1:0]  exp_r = '0;
    bit hs;
    int c = 0;
    got = '0;
    gresp = '0;
    arvalid = 1'b1;
    araddr = a;
    do begin
      @(negedge clk);
      hs = arready;
      // Expected value is the model as it stands before this edge's write commit
      if (hs) model_read(a, exp_d, exp_r);
      @(posedge clk);
      #1;
      c++;
      if (!hs && c > 60) begin
        timeout_fail("read_handshake");
        arvalid = 1'b0;
        return;
      end
    end while (!hs);
    arvalid = 1'b0;
    check("rvalid_one_cycle_after_ar", rvalid, 1'b1);
    repeat (r_dly) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    rready = 1'b1;
    @(negedge clk);
    got = rdata;
    gresp = rresp;
    check("rdata", rdata, exp_d);
    check("rresp", rresp, exp_r);
    @(posedge clk);
    #1;
    rready = 1'b0;
    check("rvalid_drops_after_r_handshake", rvalid, 1'b0);
    check("arready_back_after_r_handshake", arready, 1'b1);
    $display("[TB] RD addr=%h data=%h rresp=%0d", a, got, gresp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] vals [4];
    logic [31:0] got;
    logic [1:0]  gr;
    logic [1:0]  br;
    int aw1, b1, aw2, b2, aw3, b3;

    vals[0] = 32'h0101FFFF;
    vals[1] = 32'hABCD0001;
    vals[2] = 32'hDEAD0011;
    vals[3] = 32'hBEEF0011;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid_ready", {awready, wready, arready, bvalid, rvalid}, 5'b0);
    check("reset_resp_data", {bresp, rresp, rdata}, 36'h0);
    check("reset_reg_out", reg_out, 128'h0);
    rst = 1'b0;
    check("ready_low_before_first_edge", {awready, wready, arready}, 3'b000);
    @(posedge clk);
    #1;
    check("ready_high_after_first_edge", {awready, wready, arready}, 3'b111);

    // Full-word writes with readback
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(4 * i), vals[i], 4'hF, 0, 0, 0, aw1, b1, br);
      axi_read(5'(4 * i), 0, got, gr);
      check("readback_literal", got, vals[i]);
      check("readback_okay", gr, 2'b00);
    end
    check("reg_out_literal", reg_out, {vals[3], vals[2], vals[1], vals[0]});

    // W three cycles ahead of AW
    axi_write(5'h04, 32'h12345678, 4'hF, 3, 0, 0, aw1, b1, br);
    axi_read(5'h04, 1, got, gr);
    check("w_first_readback", got, 32'h12345678);

    // Partial strobe
    axi_write(5'h00, 32'hAAAAAAAA, 4'h5, 0, 0, 0, aw1, b1, br);
    axi_read(5'h00, 0, got, gr);
    check("strobe_5_readback", got, 32'h01AAFFAA);

    // BREADY held low; a second AW waits for the B handshake
    fork
      axi_write(5'h0C, 32'h11112222, 4'hF, 0, 0, 5, aw1, b1, br);
      begin
        repeat (2) @(posedge clk);
        #1;
        axi_write(5'h04, 32'h33334444, 4'hF, 0, 0, 0, aw2, b2, gr);
      end
    join
    check("second_aw_cycle_after_b", aw2, b1 + 1);

    // Read and write of the same register on one edge
    fork
      axi_write(5'h08, 32'h0, 4'hF, 0, 0, 0, aw3, b3, br);
      axi_read(5'h08, 0, got, gr);
    join
    check("same_edge_read_old_value", got, 32'hDEAD0011);
    axi_read(5'h08, 0, got, gr);
    check("same_edge_followup_new", got, 32'h0);

    // Out-of-range index
    axi_write(5'h10, 32'h55, 4'hF, 0, 0, 0, aw1, b1, br);
    axi_read(5'h10, 0, got, gr);
`ifdef DARC_AXIL_SLVERR_EN
    check("oor_write_slverr", br, 2'b10);
    check("oor_read_slverr", gr, 2'b10);
    check("oor_read_zero", got, 32'h0);
    check("oor_reg0_unchanged", reg_out[31:0], 32'h01AAFFAA);
`else
    check("alias_write_okay", br, 2'b00);
    check("alias_read_okay", gr, 2'b00);
    check("alias_read_value", got, 32'h55);
    check("alias_reg0_value", reg_out[31:0], 32'h55);
`endif

    // Reset between the AW and W handshakes
    awaddr = 5'h04;
    awvalid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    #2;
    rst = 1'b1;
    for (int k = 0; k < NR; k++) model[k] = 32'h0;
    #1;
    check("midreset_outputs_zero", {awready, wready, arready, bvalid, rvalid, bresp, rresp}, 9'b0);
    check("midreset_reg_out_zero", reg_out, 128'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_midreset", {awready, wready, arready}, 3'b111);
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(4 * i), 0, got, gr);
      check("reg_zero_after_reset", got, 32'h0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 200; n++) begin
      int kind;
      logic [4:0]  wa, ra;
      logic [31:0] wd;
      logic [3:0]  ws;
      kind = int'($urandom_range(0, 2));
      wa = 5'($urandom_range(0, 31));
      ra = 5'($urandom_range(0, 31));
      wd = $urandom;
      ws = 4'($urandom_range(0, 15));
      if (kind == 0) begin
        axi_write(wa, wd, ws, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), aw1, b1, br);
      end else if (kind == 1) begin
        axi_read(ra, int'($urandom_range(0, 3)), got, gr);
      end else begin
        fork
          axi_write(wa, wd, ws, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), aw1, b1, br);
          axi_read(ra, int'($urandom_range(0, 2)), got, gr);
        join
      end
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
